mux4_rr_collector: RTL and testbench
====================================

Name: mux4_rr_collector

Overview:
- 4-to-1 registered collector. It merges four independent valid/ready input lanes into one output stream.
- Each output word carries its 2-bit source index on `s`, so a downstream 1x4 demux can route words back to their lanes.
- Fair round-robin arbitration between lanes; one-deep output buffer.
- Sits in front of the demux path as the gathering end of the same lane/select interface.

Parameters:
- W, 1, data width per lane and on output `y`.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- i_valid  input  4  per-lane valid; bit k belongs to lane k.
- i  input  4*W  lane data; lane k is bits [k*W +: W].
- i_ready  output  4  per-lane accept; at most one bit high (one-hot or zero).
- y  output  W  registered output data.
- s  output  2  registered source lane index of `y`.
- y_valid  output  1  output word valid.
- y_ready  input  1  downstream accept.

Behaviour:
- Reset (async assert, synchronous release): y=0, s=0, y_valid=0, ptr=0, state=EMPTY.
- i_ready is combinational from the current state; it is 0 while rst is high.
- Transfer rules:
  - Input lane k transfers on a clk edge when i_valid[k] and i_ready[k] are both high.
  - Output transfers when y_valid and y_ready are both high.
- load = (state==EMPTY) or (y_valid and y_ready). The output slot may refill in the same cycle it drains, giving 1 word/cycle throughput.
- Arbitration:
  - Search lanes ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first lane with i_valid set is granted g.
  - i_ready[g] = load; all other i_ready bits are 0.
  - No valid lane means no grant and i_ready=0.
- On a grant with load, at the next edge: y <= lane g data, s <= g, y_valid <= 1, ptr <= (g+1) mod 4, state <= FULL.
- State machine:
  - EMPTY -> FULL on a grant.
  - FULL stays FULL if y_ready=0 (y, s, y_valid held stable, no grant issued).
  - FULL stays FULL on drain plus simultaneous grant (new word loaded).
  - FULL -> EMPTY on drain with no grant.
- Latency: an input word accepted at edge n is visible on y/s at edge n (registered), i.e. 1 cycle from the i_valid presentation cycle.
- Held output: y and s must not change while y_valid=1 and y_ready=0, even if i/i_valid toggle.
- Wrap-around: ptr 3 -> 0. A grant of lane 3 makes lane 0 next highest priority.
- Fairness: with all four lanes valid continuously and y_ready=1, grants follow 0,1,2,3,0,… Any continuously valid lane is served within 4 output transfers.
- ptr only advances on an actual grant. Idle cycles leave ptr unchanged.
- Simultaneous events: drain and refill in the same cycle are both performed. The newly granted word replaces the drained one with no bubble.
- Reset mid-operation: the buffered word is discarded, y_valid drops immediately (async), and ptr returns to 0.
- y_valid and data are undefined-free: no X may propagate from unselected lanes.

Decomposition:
- Shared package:
  - Constants N_CH=4 and SEL_W=2.
  - State enum {EMPTY, FULL}.
  - A lane-index typedef (SEL_W bits), reused by the 1x4 demux.
- Sub-module rr_arb4:
  - Inputs: req[3:0], ptr[1:0], en.
  - Outputs: gnt[3:0] one-hot, gnt_idx[1:0], any.
  - Purely combinational rotate-priority encoder.
- The top level holds the output register, state and ptr.

Test Plan:
- Reset: apply rst mid-stream while y_valid=1 -> y_valid=0, y=0, s=0 immediately; after release, first grant with all lanes valid goes to lane 0.
- Single lane: W=8, only lane 2 valid with data 0xA5, y_ready=1 -> next edge y=0xA5, s=2, y_valid=1; i_ready=4'b0100 on the accepting cycle; a second word 0x3C follows back-to-back with no bubble.
- Round-robin: all four lanes valid continuously (data 0x10,0x11,0x12,0x13), y_ready=1 -> s sequence 0,1,2,3,0,1; y matches lane data; exactly one i_ready bit high each cycle.
- Backpressure: hold y_ready=0 for 5 cycles with lanes valid -> y/s/y_valid unchanged, i_ready=0000 throughout; on y_ready=1, drain and refill in the same cycle, and the next s = previous s+1 (mod 4) among valid lanes.
- Skip and wrap: ptr=3, only lanes 1 and 3 valid -> grant lane 3 then lane 1. ptr=0, only lane 3 valid -> grant lane 3 and ptr wraps to 0.
- Idle: all i_valid=0 for 3 cycles after a drain -> y_valid=0, ptr unchanged; a lane raised later is served on the next edge.

Source files
------------

// File: rtl/mux4_rr_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux4_rr_collector_pkg
// Description : Shared lane constants, lane-index type and collector state enum.
// Revision    : 1.0 - initial release
// ============================================================================
package mux4_rr_collector_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    // Lane index shared with the 1x4 demux on the return path.
    typedef logic [SEL_W-1:0] lane_idx_t;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage : mux4_rr_collector_pkg
`default_nettype wire

// File: rtl/mux4_rr_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : mux4_rr_collector_if
// Description : Four-lane gather side plus single tagged output stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux4_rr_collector_if #(
    parameter int W = 1
);
    import mux4_rr_collector_pkg::*;

    logic [N_CH-1:0]   i_valid;
    logic [N_CH*W-1:0] i;
    logic [N_CH-1:0]   i_ready;
    logic [W-1:0]      y;
    lane_idx_t         s;
    logic              y_valid;
    logic              y_ready;

    modport master (
        output i_valid,
        output i,
        output y_ready,
        input  i_ready,
        input  y,
        input  s,
        input  y_valid
    );

    modport slave (
        input  i_valid,
        input  i,
        input  y_ready,
        output i_ready,
        output y,
        output s,
        output y_valid
    );

endinterface : mux4_rr_collector_if
`default_nettype wire

// File: rtl/mux4_rr_collector_rr_arb4.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb4
// Description : Combinational rotate-priority encoder; lane ptr has top priority.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb4
    import mux4_rr_collector_pkg::*;
(
    input  wire logic [N_CH-1:0] req,
    input  wire lane_idx_t       ptr,
    input  wire logic            en,
    output logic [N_CH-1:0]      gnt,
    output lane_idx_t            gnt_idx,
    output logic                 any
);

    lane_idx_t w_idx;

    always_comb begin
        w_idx   = '0;
        gnt_idx = ptr;
        any     = 1'b0;
        // Walk from the farthest offset back to ptr so the nearest request wins.
        for (int k = N_CH - 1; k >= 0; k--) begin
            w_idx = ptr + lane_idx_t'(k);
            if (req[w_idx]) begin
                any     = 1'b1;
                gnt_idx = w_idx;
            end
        end
        gnt = '0;
        if (any && en) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule : rr_arb4
`default_nettype wire

// File: rtl/mux4_rr_collector.sv
`default_nettype none
// ============================================================================
// Module      : mux4_rr_collector
// Description : 4-to-1 round-robin collector with one-deep tagged output slot.
// Revision    : 1.0 - initial release
// ============================================================================
module mux4_rr_collector
    import mux4_rr_collector_pkg::*;
#(
    parameter int W = 1
) (
    input  wire logic            clk,
    input  wire logic            rst,
    mux4_rr_collector_if.slave   bus
);

    state_t          r_state;
    lane_idx_t       r_ptr;
    logic [W-1:0]    r_y;
    lane_idx_t       r_s;
    logic            r_y_valid;

    logic            w_load;
    logic            w_en;
    logic            w_any;
    logic            w_take;
    logic [N_CH-1:0] w_gnt;
    lane_idx_t       w_gnt_idx;
    logic [W-1:0]    w_lane_data;

    // Slot is free when empty, or when its word leaves on this edge.
    assign w_load = (r_state == EMPTY) || (r_y_valid && bus.y_ready);
    assign w_en   = w_load && !rst;
    assign w_take = w_any && w_en;

    rr_arb4 u_arb (
        .req     (bus.i_valid),
        .ptr     (r_ptr),
        .en      (w_en),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any     (w_any)
    );

    // Only the granted lane reaches the register, so idle lanes cannot leak X.
    always_comb begin
        w_lane_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (w_gnt_idx == lane_idx_t'(k)) begin
                w_lane_data = bus.i[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= EMPTY;
            r_ptr     <= '0;
            r_y       <= '0;
            r_s       <= '0;
            r_y_valid <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_take) begin
                        r_y       <= w_lane_data;
                        r_s       <= w_gnt_idx;
                        r_y_valid <= 1'b1;
                        r_ptr     <= w_gnt_idx + lane_idx_t'(1);
                        r_state   <= FULL;
                    end
                end
                FULL: begin
                    if (w_take) begin
                        r_y       <= w_lane_data;
                        r_s       <= w_gnt_idx;
                        r_y_valid <= 1'b1;
                        r_ptr     <= w_gnt_idx + lane_idx_t'(1);
                        r_state   <= FULL;
                    end else if (bus.y_ready) begin
                        r_y_valid <= 1'b0;
                        r_state   <= EMPTY;
                    end
                end
                default: begin
                    r_y_valid <= 1'b0;
                    r_state   <= EMPTY;
                end
            endcase
        end
    end

    assign bus.i_ready = w_gnt;
    assign bus.y       = r_y;
    assign bus.s       = r_s;
    assign bus.y_valid = r_y_valid;

endmodule : mux4_rr_collector
`default_nettype wire

// File: tb/tb_mux4_rr_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux4_rr_collector
// Description : Scenario bench with an output scoreboard for the collector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux4_rr_collector;
    import mux4_rr_collector_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux4_rr_collector_if #(.W(W)) bus ();

    mux4_rr_collector #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [1:0]   s;
        logic [W-1:0] y;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input logic [3:0] v, input logic [7:0] d3, input logic [7:0] d2,
                             input logic [7:0] d1, input logic [7:0] d0);
        bus.i_valid = v;
        bus.i       = {d3, d2, d1, d0};
    endtask

    task automatic push_exp(input logic [1:0] s, input logic [7:0] y);
        exp_t e;
        e.s = s;
        e.y = y;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        set_lanes(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
        bus.y_ready = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Output monitor: every output transfer must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && bus.y_valid === 1'b1 && bus.y_ready === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got s=%0d y=%h, required no output", bus.s, bus.y);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({bus.s, bus.y} !== {e.s, e.y}) begin
                    n_fail++;
                    $display("FAIL sb_word: got s=%0d y=%h, required s=%0d y=%h",
                             bus.s, bus.y, e.s, e.y);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        set_lanes(4'hF, 8'h13, 8'h12, 8'h11, 8'h10);
        bus.y_ready = 1'b1;
        next_cycle();
        n_checks++; if (bus.y_valid !== 1'b0) begin n_fail++; $display("FAIL rst_yv: got %b required 0", bus.y_valid); end
        n_checks++; if (bus.y !== 8'h00) begin n_fail++; $display("FAIL rst_y: got %h required 00", bus.y); end
        n_checks++; if (bus.s !== 2'd0) begin n_fail++; $display("FAIL rst_s: got %0d required 0", bus.s); end
        n_checks++; if (bus.i_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready: got %b required 0000", bus.i_ready); end

        rst = 1'b0;
        bus.y_ready = 1'b0;
        #1;
        n_checks++; if (bus.i_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_first_ready: got %b required 0001", bus.i_ready); end
        next_cycle();
        n_checks++; if (bus.y_valid !== 1'b1 || bus.y !== 8'h10 || bus.s !== 2'd0) begin
            n_fail++; $display("FAIL rst_first_word: got v=%b s=%0d y=%h required v=1 s=0 y=10", bus.y_valid, bus.s, bus.y);
        end
        n_checks++; if (bus.i_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_full_ready: got %b required 0000", bus.i_ready); end

        // Asynchronous assertion between edges must clear the slot at once.
        rst = 1'b1;
        #1;
        n_checks++; if (bus.y_valid !== 1'b0 || bus.y !== 8'h00 || bus.s !== 2'd0) begin
            n_fail++; $display("FAIL rst_async: got v=%b s=%0d y=%h required v=0 s=0 y=00", bus.y_valid, bus.s, bus.y);
        end
        next_cycle();
        rst = 1'b0;
        bus.y_ready = 1'b1;
        #1;
        n_checks++; if (bus.i_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_ptr_cleared: got %b required 0001", bus.i_ready); end
        push_exp(2'd0, 8'h10);
        next_cycle();
        n_checks++; if (bus.y_valid !== 1'b1 || bus.s !== 2'd0) begin
            n_fail++; $display("FAIL rst_regrant: got v=%b s=%0d required v=1 s=0", bus.y_valid, bus.s);
        end
        set_lanes(4'h0, 8'h13, 8'h12, 8'h11, 8'h10);
        next_cycle();
        n_checks++; if (bus.y_valid !== 1'b0) begin n_fail++; $display("FAIL rst_drain: got %b required 0", bus.y_valid); end
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL rst_sb_left: got %0d required 0", sb.size()); end
    endtask

    task automatic test_single_lane();
        do_reset();
        bus.y_ready = 1'b1;
        set_lanes(4'b0100, 8'h00, 8'hA5, 8'h00, 8'h00);
        #1;
        n_checks++; if (bus.i_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready1: got %b required 0100", bus.i_ready); end
        push_exp(2'd2, 8'hA5);
        next_cycle();
        n_checks++; if (bus.y_valid !== 1'b1 || bus.y !== 8'hA5 || bus.s !== 2'd2) begin
            n_fail++; $display("FAIL single_word1: got v=%b s=%0d y=%h required v=1 s=2 y=a5", bus.y_valid, bus.s, bus.y);
        end
        set_lanes(4'b0100, 8'h00, 8'h3C, 8'h00, 8'h00);
        #1;
        n_checks++; if (bus.i_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready2: got %b required 0100", bus.i_ready); end
        push_exp(2'd2, 8'h3C);
        next_cycle();
        n_checks++; if (bus.y_valid !== 1'b1 || bus.y !== 8'h3C || bus.s !== 2'd2) begin
            n_fail++; $display("FAIL single_b2b: got v=%b s=%0d y=%h required v=1 s=2 y=3c", bus.y_valid, bus.s, bus.y);
        end
        set_lanes(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
        next_cycle();
        n_checks++; if (bus.y_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b required 0", bus.y_valid); end
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL single_sb_left: got %0d required 0", sb.size()); end
    endtask

    task automatic test_round_robin();
        logic [1:0] lane;
        do_reset();
        bus.y_ready = 1'b1;
        set_lanes(4'hF, 8'h13, 8'h12, 8'h11, 8'h10);
        for (int c = 0; c < 6; c++) begin
            lane = 2'(c % 4);
            #1;
            n_checks++; if (bus.i_ready !== (4'b0001 << lane) || $countones(bus.i_ready) != 1) begin
                n_fail++; $display("FAIL rr_ready: cycle %0d got %b required %b", c, bus.i_ready, 4'b0001 << lane);
            end
            push_exp(lane, 8'h10 + 8'(lane));
            next_cycle();
            n_checks++; if (bus.s !== lane || bus.y !== 8'h10 + 8'(lane)) begin
                n_fail++; $display("FAIL rr_seq: cycle %0d got s=%0d y=%h required s=%0d y=%h", c, bus.s, bus.y, lane, 8'h10 + 8'(lane));
            end
        end
        set_lanes(4'h0, 8'h13, 8'h12, 8'h11, 8'h10);
        next_cycle();
        n_checks++; if (bus.y_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain: got %b required 0", bus.y_valid); end
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL rr_sb_left: got %0d required 0", sb.size()); end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.y_ready = 1'b1;
        set_lanes(4'hF, 8'h13, 8'h12, 8'h11, 8'h10);
        #1;
        push_exp(2'd0, 8'h10);
        next_cycle();
        bus.y_ready = 1'b0;
        for (int h = 0; h < 5; h++) begin
            bus.i       = $urandom;
            bus.i_valid = (h % 2 == 1) ? 4'hF : 4'h5;
            #1;
            n_checks++; if (bus.i_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready: cycle %0d got %b required 0000", h, bus.i_ready); end
            n_checks++; if (bus.y_valid !== 1'b1 || bus.y !== 8'h10 || bus.s !== 2'd0) begin
                n_fail++; $display("FAIL bp_hold: cycle %0d got v=%b s=%0d y=%h required v=1 s=0 y=10", h, bus.y_valid, bus.s, bus.y);
            end
            next_cycle();
        end
        set_lanes(4'hF, 8'h13, 8'h12, 8'h11, 8'h10);
        bus.y_ready = 1'b1;
        #1;
        n_checks++; if (bus.i_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_refill_ready: got %b required 0010", bus.i_ready); end
        push_exp(2'd1, 8'h11);
        next_cycle();
        n_checks++; if (bus.y_valid !== 1'b1 || bus.s !== 2'd1 || bus.y !== 8'h11) begin
            n_fail++; $display("FAIL bp_refill: got v=%b s=%0d y=%h required v=1 s=1 y=11", bus.y_valid, bus.s, bus.y);
        end
        set_lanes(4'h0, 8'h13, 8'h12, 8'h11, 8'h10);
        next_cycle();
        n_checks++; if (bus.y_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b required 0", bus.y_valid); end
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL bp_sb_left: got %0d required 0", sb.size()); end
    endtask

    task automatic test_skip_wrap();
        do_reset();
        bus.y_ready = 1'b1;
        // Lane 2 alone moves the pointer to 3.
        set_lanes(4'b0100, 8'h00, 8'h22, 8'h00, 8'h00);
        #1;
        push_exp(2'd2, 8'h22);
        next_cycle();
        set_lanes(4'b1010, 8'h33, 8'h00, 8'h31, 8'h00);
        #1;
        n_checks++; if (bus.i_ready !== 4'b1000) begin n_fail++; $display("FAIL skip_ready3: got %b required 1000", bus.i_ready); end
        push_exp(2'd3, 8'h33);
        next_cycle();
        #1;
        n_checks++; if (bus.i_ready !== 4'b0010) begin n_fail++; $display("FAIL skip_ready1: got %b required 0010", bus.i_ready); end
        push_exp(2'd1, 8'h31);
        next_cycle();
        n_checks++; if (bus.s !== 2'd1 || bus.y !== 8'h31) begin
            n_fail++; $display("FAIL skip_word1: got s=%0d y=%h required s=1 y=31", bus.s, bus.y);
        end
        // Pointer is now 2; lane 3 alone twice exercises the 3 -> 0 wrap.
        set_lanes(4'b1000, 8'h33, 8'h00, 8'h00, 8'h00);
        #1;
        n_checks++; if (bus.i_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_ready_a: got %b required 1000", bus.i_ready); end
        push_exp(2'd3, 8'h33);
        next_cycle();
        set_lanes(4'b1000, 8'h44, 8'h00, 8'h00, 8'h00);
        #1;
        n_checks++; if (bus.i_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_ready_b: got %b required 1000", bus.i_ready); end
        push_exp(2'd3, 8'h44);
        next_cycle();
        set_lanes(4'hF, 8'h53, 8'h52, 8'h51, 8'h50);
        #1;
        n_checks++; if (bus.i_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_to_lane0: got %b required 0001", bus.i_ready); end
        push_exp(2'd0, 8'h50);
        next_cycle();
        set_lanes(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
        next_cycle();
        n_checks++; if (bus.y_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_drain: got %b required 0", bus.y_valid); end
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL wrap_sb_left: got %0d required 0", sb.size()); end
    endtask

    task automatic test_idle();
        do_reset();
        bus.y_ready = 1'b1;
        set_lanes(4'b0001, 8'h00, 8'h00, 8'h00, 8'h77);
        #1;
        push_exp(2'd0, 8'h77);
        next_cycle();
        set_lanes(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
        next_cycle();
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (bus.y_valid !== 1'b0 || bus.i_ready !== 4'b0000) begin
                n_fail++; $display("FAIL idle_quiet: cycle %0d got v=%b rdy=%b required v=0 rdy=0000", c, bus.y_valid, bus.i_ready);
            end
            next_cycle();
        end
        set_lanes(4'hF, 8'h13, 8'h12, 8'h11, 8'h10);
        #1;
        n_checks++; if (bus.i_ready !== 4'b0010) begin n_fail++; $display("FAIL idle_ptr_kept: got %b required 0010", bus.i_ready); end
        push_exp(2'd1, 8'h11);
        next_cycle();
        n_checks++; if (bus.y_valid !== 1'b1 || bus.s !== 2'd1) begin
            n_fail++; $display("FAIL idle_wake: got v=%b s=%0d required v=1 s=1", bus.y_valid, bus.s);
        end
        set_lanes(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
        next_cycle();
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL idle_sb_left: got %0d required 0", sb.size()); end
    endtask

    initial begin
        bus.i_valid = 4'h0;
        bus.i       = '0;
        bus.y_ready = 1'b0;
        test_reset();
        test_single_lane();
        test_round_robin();
        test_backpressure();
        test_skip_wrap();
        test_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mux4_rr_collector
`default_nettype wire
